// File: rtl/cordic_pkg.sv
// Shared constants for the CORDIC arbiter: Q2.16 angle format, the pi/2 range
// limit, iteration defaults and the sequencer state encoding.
package cordic_pkg;

  localparam int ANGLE_W  = 18;
  localparam int Q_INT    = 2;
  localparam int Q_FRAC   = 16;
  localparam int ITER_DEF = 16;
  localparam int IDX_W    = 5;

  localparam logic [ANGLE_W-1:0] PI_2      = 18'h19220;
  localparam logic [ANGLE_W-1:0] ANGLE_MAX = PI_2;

  localparam int ST_W = 3;
  typedef logic [ST_W-1:0] state_t;

  localparam logic [ST_W-1:0] ST_IDLE = 3'd0;
  localparam logic [ST_W-1:0] ST_LOAD = 3'd1;
  localparam logic [ST_W-1:0] ST_ITER = 3'd2;
  localparam logic [ST_W-1:0] ST_CAPT = 3'd3;
  localparam logic [ST_W-1:0] ST_RESP = 3'd4;

  // Signed range test; the most negative code (-2^17) is always outside +-max.
  function automatic logic angle_ok(input logic [ANGLE_W-1:0] a,
                                    input logic [ANGLE_W-1:0] max);
    logic signed [ANGLE_W-1:0] s;
    logic signed [ANGLE_W-1:0] m;
    s = a;
    m = max;
    return (s <= m) && (s >= -m);
  endfunction

endpackage

// File: rtl/cordic_arbiter_rr_arb2.sv
// Two-way round-robin arbiter: combinational grant from the request pair and
// the remembered last grant, which only advances when the caller accepts.
module rr_arb2
  import cordic_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req_i,
  input  logic       update_i,
  output logic       grant_valid_o,
  output logic       grant_id_o
);

  logic last_q;
  logic last_d;

  always_comb begin
    grant_valid_o = |req_i;
    if (&req_i) begin
      grant_id_o = ~last_q;
    end else begin
      grant_id_o = req_i[1];
    end
    last_d = update_i ? grant_id_o : last_q;
  end

  // Reset to 1 so requester 0 wins the first contested round.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/cordic_arbiter.sv
// Sequencer sharing one iterative CORDIC core between two requesters:
// arbitrate, load, step ITER micro-rotations, capture, return tagged result.
module cordic_arbiter
  import cordic_pkg::*;
#(
  parameter int                  ANGLE_W_P = ANGLE_W,
  parameter int                  ITER      = ITER_DEF,
  parameter int                  IDX_W_P   = IDX_W,
  parameter logic [ANGLE_W-1:0]  ANGLE_LIM = ANGLE_MAX
) (
  input  logic                 clock,
  input  logic                 init,
  input  logic                 req0,
  input  logic [ANGLE_W_P-1:0] angle0,
  output logic                 ack0,
  input  logic                 req1,
  input  logic [ANGLE_W_P-1:0] angle1,
  output logic                 ack1,
  output logic                 core_load,
  output logic [ANGLE_W_P-1:0] core_angle,
  output logic                 core_step,
  output logic [IDX_W_P-1:0]   core_index,
  input  logic [ANGLE_W_P-1:0] core_cos,
  input  logic [ANGLE_W_P-1:0] core_sin,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic                 rsp_id,
  output logic                 rsp_err,
  output logic [ANGLE_W_P-1:0] rsp_cos,
  output logic [ANGLE_W_P-1:0] rsp_sin,
  output logic [ST_W-1:0]      dbg_state
);

  localparam logic [IDX_W_P-1:0] IDX_LAST = IDX_W_P'(ITER - 1);

  // Handshakes: reqN is held by the client until its one-cycle ackN; a result
  // transfers on any rising edge where rsp_valid && rsp_ready are both high.

  state_t               state_q, state_d;
  logic [IDX_W_P-1:0]   idx_q, idx_d;
  logic [ANGLE_W_P-1:0] angle_q, angle_d;
  logic                 id_q, id_d;
  logic                 err_q, err_d;
  logic                 ack0_q, ack0_d;
  logic                 ack1_q, ack1_d;
  logic                 rsp_id_q, rsp_id_d;
  logic                 rsp_err_q, rsp_err_d;
  logic [ANGLE_W_P-1:0] rsp_cos_q, rsp_cos_d;
  logic [ANGLE_W_P-1:0] rsp_sin_q, rsp_sin_d;

  logic                 grant_valid;
  logic                 grant_id;
  logic                 accept;
  logic [ANGLE_W_P-1:0] sel_angle;
  logic                 sel_ok;

  assign accept    = (state_q == ST_IDLE) && grant_valid;
  assign sel_angle = grant_id ? angle1 : angle0;
  assign sel_ok    = angle_ok(sel_angle, ANGLE_LIM);

  rr_arb2 u_arb (
    .clk_i        (clock),
    .rst_i        (init),
    .req_i        ({req1, req0}),
    .update_i     (accept),
    .grant_valid_o(grant_valid),
    .grant_id_o   (grant_id)
  );

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    angle_d   = angle_q;
    id_d      = id_q;
    err_d     = err_q;
    ack0_d    = 1'b0;
    ack1_d    = 1'b0;
    rsp_id_d  = rsp_id_q;
    rsp_err_d = rsp_err_q;
    rsp_cos_d = rsp_cos_q;
    rsp_sin_d = rsp_sin_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          angle_d = sel_angle;
          id_d    = grant_id;
          err_d   = ~sel_ok;
          ack0_d  = ~grant_id;
          ack1_d  = grant_id;
          // Out-of-range angles skip the core entirely.
          state_d = sel_ok ? ST_LOAD : ST_CAPT;
        end
      end
      ST_LOAD: begin
        idx_d   = '0;
        state_d = ST_ITER;
      end
      ST_ITER: begin
        if (idx_q == IDX_LAST) begin
          idx_d   = '0;
          state_d = ST_CAPT;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      ST_CAPT: begin
        rsp_id_d  = id_q;
        rsp_err_d = err_q;
        rsp_cos_d = err_q ? '0 : core_cos;
        rsp_sin_d = err_q ? '0 : core_sin;
        state_d   = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge init) begin
    if (init) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      angle_q   <= '0;
      id_q      <= 1'b0;
      err_q     <= 1'b0;
      ack0_q    <= 1'b0;
      ack1_q    <= 1'b0;
      rsp_id_q  <= 1'b0;
      rsp_err_q <= 1'b0;
      rsp_cos_q <= '0;
      rsp_sin_q <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      angle_q   <= angle_d;
      id_q      <= id_d;
      err_q     <= err_d;
      ack0_q    <= ack0_d;
      ack1_q    <= ack1_d;
      rsp_id_q  <= rsp_id_d;
      rsp_err_q <= rsp_err_d;
      rsp_cos_q <= rsp_cos_d;
      rsp_sin_q <= rsp_sin_d;
    end
  end

  // Core strobes decode straight from the registered state, so they clear
  // together with it on reset.
  assign core_load  = (state_q == ST_LOAD);
  assign core_step  = (state_q == ST_ITER);
  assign core_index = idx_q;
  assign core_angle = angle_q;
  assign rsp_valid  = (state_q == ST_RESP);
  assign ack0       = ack0_q;
  assign ack1       = ack1_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_err    = rsp_err_q;
  assign rsp_cos    = rsp_cos_q;
  assign rsp_sin    = rsp_sin_q;
  assign dbg_state  = state_q;

  a_load_step_excl: assert property (@(posedge clock) disable iff (init)
    !(core_load && core_step));
  a_idx_bound: assert property (@(posedge clock) disable iff (init)
    core_index <= IDX_LAST);
  a_ack_onehot: assert property (@(posedge clock) disable iff (init)
    !(ack0 && ack1));

endmodule

// File: tb/tb_cordic_arbiter.sv
// Randomized bench for cordic_arbiter against a timeline model of each
// transaction (cycles since acceptance) plus an expected-response queue.
module tb_cordic_arbiter;
  import cordic_pkg::*;

  localparam int ITER_N = 16;
  localparam int AMAX   = 'h19220;

  logic               clock = 1'b0;
  logic               init;
  logic               req0, req1;
  logic [ANGLE_W-1:0] angle0, angle1;
  logic               ack0, ack1;
  logic               core_load, core_step;
  logic [ANGLE_W-1:0] core_angle;
  logic [IDX_W-1:0]   core_index;
  logic [ANGLE_W-1:0] core_cos, core_sin;
  logic               rsp_valid, rsp_ready, rsp_id, rsp_err;
  logic [ANGLE_W-1:0] rsp_cos, rsp_sin;
  logic [ST_W-1:0]    dbg_state;

  cordic_arbiter dut (
    .clock(clock), .init(init),
    .req0(req0), .angle0(angle0), .ack0(ack0),
    .req1(req1), .angle1(angle1), .ack1(ack1),
    .core_load(core_load), .core_angle(core_angle), .core_step(core_step),
    .core_index(core_index), .core_cos(core_cos), .core_sin(core_sin),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_err(rsp_err), .rsp_cos(rsp_cos), .rsp_sin(rsp_sin),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [37:0] exp_q[$];
  logic        dut_grants[$];

  bit          m_busy;
  int          m_d;
  bit          m_err;
  logic        m_id;
  logic        m_lg;
  logic [17:0] m_angle;
  int          n_acc;
  int          dut_rsp;
  int          dut_steps;

  bit traffic_en;
  int rdy_mode;
  int hold_cnt;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic bit legal(input logic [17:0] a);
    int v;
    v = $signed(a);
    return (v >= -AMAX) && (v <= AMAX);
  endfunction

  function automatic logic [17:0] rand_angle();
    int v;
    case ($urandom_range(0, 9))
      0: return 18'h00000;
      1: return 18'h19220;
      2: return 18'h26DE0;
      3: return 18'h19221;
      4: return 18'h20000;
      5: return 18'h26DDF;
      6: return 18'($urandom);
      default: begin
        v = int'($urandom_range(0, 2 * AMAX)) - AMAX;
        return 18'(v);
      end
    endcase
  endfunction

  function automatic bit m_valid();
    return m_busy && (m_err ? (m_d >= 2) : (m_d >= ITER_N + 3));
  endfunction

  task automatic model_reset();
    if (m_busy) n_acc--;
    m_busy  = 1'b0;
    m_d     = 0;
    m_err   = 1'b0;
    m_id    = 1'b0;
    m_lg    = 1'b1;
    m_angle = '0;
    exp_q.delete();
  endtask

  // Advance the reference at a rising edge using the inputs held across it.
  task automatic model_edge();
    if (init) begin
      model_reset();
      return;
    end
    if (m_busy) begin
      if (m_valid() && rsp_ready) begin
        m_busy = 1'b0;
        if (exp_q.size() != 0) void'(exp_q.pop_front());
      end else begin
        if (!m_err && m_d == ITER_N + 2) exp_q.push_back({m_id, 1'b0, core_cos, core_sin});
        m_d++;
      end
    end else if (req0 || req1) begin
      m_id    = (req0 && req1) ? ~m_lg : (req0 ? 1'b0 : 1'b1);
      m_lg    = m_id;
      m_angle = m_id ? angle1 : angle0;
      m_err   = !legal(m_angle);
      m_busy  = 1'b1;
      m_d     = 1;
      n_acc++;
      if (m_err) exp_q.push_back({m_id, 1'b1, 36'd0});
    end
  endtask

  task automatic check_outputs();
    bit e_load, e_step;
    int e_idx;
    e_load = m_busy && !m_err && (m_d == 1);
    e_step = m_busy && !m_err && (m_d >= 2) && (m_d <= ITER_N + 1);
    e_idx  = e_step ? m_d - 2 : 0;
    chk("ack0", 64'(ack0), 64'(m_busy && m_d == 1 && m_id == 1'b0));
    chk("ack1", 64'(ack1), 64'(m_busy && m_d == 1 && m_id == 1'b1));
    chk("core_load", 64'(core_load), 64'(e_load));
    chk("core_step", 64'(core_step), 64'(e_step));
    chk("core_index", 64'(core_index), 64'(e_idx));
    chk("core_angle", 64'(core_angle), 64'(m_angle));
    chk("rsp_valid", 64'(rsp_valid), 64'(m_valid()));
    if (m_valid()) begin
      chk("rsp_pending", 64'(exp_q.size() != 0), 64'(1));
      if (exp_q.size() != 0)
        chk("rsp_data", 64'({rsp_id, rsp_err, rsp_cos, rsp_sin}), 64'(exp_q[0]));
    end
    if (ack0) dut_grants.push_back(1'b0);
    if (ack1) dut_grants.push_back(1'b1);
    if (core_step) dut_steps++;
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive();
    if (ack0) req0 = 1'b0;
    if (ack1) req1 = 1'b0;
    if (traffic_en) begin
      if (!req0 && $urandom_range(0, 3) == 0) begin req0 = 1'b1; angle0 = rand_angle(); end
      if (!req1 && $urandom_range(0, 3) == 0) begin req1 = 1'b1; angle1 = rand_angle(); end
    end
    core_cos = 18'($urandom);
    core_sin = 18'($urandom);
    case (rdy_mode)
      0: rsp_ready = 1'b1;
      1: rsp_ready = 1'($urandom_range(0, 1));
      default: begin
        hold_cnt  = m_valid() ? hold_cnt + 1 : 0;
        rsp_ready = (hold_cnt > 10);
      end
    endcase
    if (rsp_valid && rsp_ready) dut_rsp++;
  endtask

  task automatic tick();
    @(posedge clock);
    model_edge();
    @(negedge clock);
    cyc++;
    check_outputs();
    drive();
  endtask

  task automatic drain(input string tag, input int bound);
    int k;
    k = 0;
    while ((req0 || req1 || m_busy) && k < bound) begin
      tick();
      k++;
    end
    chk(tag, 64'(k < bound), 64'(1));
  endtask

  task automatic do_reset();
    init = 1'b1;
    req0 = 1'b0;
    req1 = 1'b0;
    model_reset();
    repeat (2) tick();
    init = 1'b0;
  endtask

  task automatic request(input logic id, input logic [17:0] a);
    if (id) begin req1 = 1'b1; angle1 = a; end
    else begin req0 = 1'b1; angle0 = a; end
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int k;
    init = 1'b1; req0 = 1'b0; req1 = 1'b0; angle0 = '0; angle1 = '0;
    core_cos = '0; core_sin = '0; rsp_ready = 1'b1;
    traffic_en = 1'b0; rdy_mode = 0; hold_cnt = 0;
    n_acc = 0; dut_rsp = 0; dut_steps = 0;
    model_reset();
    #2;
    chk("rst_state", 64'(dbg_state), 64'(ST_IDLE));
    chk("rst_outs", 64'({ack0, ack1, core_load, core_step, core_index, rsp_valid, rsp_id, rsp_err}), 64'(0));
    chk("rst_data", 64'({core_angle, rsp_cos, rsp_sin}), 64'(0));
    do_reset();

    // single in-range request
    request(1'b0, 18'h0C910);
    drain("single_timeout", 60);

    // contested requests: order 0, 1, then 0 again
    do_reset();
    dut_grants.delete();
    request(1'b0, 18'h01000);
    request(1'b1, 18'h3F000);
    k = 0;
    while (dut_grants.size() < 2 && k < 80) begin tick(); k++; end
    chk("grant2_timeout", 64'(k < 80), 64'(1));
    request(1'b0, 18'h05555);
    drain("rr_timeout", 80);
    chk("grant_count", 64'(dut_grants.size()), 64'(3));
    if (dut_grants.size() == 3) begin
      chk("grant_first", 64'(dut_grants[0]), 64'(0));
      chk("grant_second", 64'(dut_grants[1]), 64'(1));
      chk("grant_third", 64'(dut_grants[2]), 64'(0));
    end

    // range boundaries
    request(1'b1, 18'h19221); drain("oor_pos_timeout", 20);
    request(1'b0, 18'h26DE0); drain("neg_max_timeout", 40);
    request(1'b1, 18'h20000); drain("min_code_timeout", 20);

    // backpressure, with a competing request raised during the stall
    rdy_mode = 2;
    request(1'b0, 18'h0A000);
    k = 0;
    while (!m_valid() && k < 40) begin tick(); k++; end
    chk("bp_valid_timeout", 64'(k < 40), 64'(1));
    request(1'b0, 18'h11111);
    drain("bp_timeout", 120);
    rdy_mode = 0;

    // asynchronous reset in the middle of the iteration phase
    request(1'b0, 18'h02345);
    k = 0;
    while (!(m_busy && m_d == 9) && k < 40) begin tick(); k++; end
    chk("mid_iter_timeout", 64'(k < 40), 64'(1));
    chk("pre_rst_index", 64'(core_index), 64'(7));
    #2 init = 1'b1;
    #1;
    chk("async_rst_outs", 64'({ack0, ack1, core_load, core_step, core_index, rsp_valid, rsp_id, rsp_err}), 64'(0));
    chk("async_rst_data", 64'({core_angle, rsp_cos, rsp_sin}), 64'(0));
    req0 = 1'b0;
    model_reset();
    repeat (2) tick();
    init = 1'b0;
    repeat (30) tick();
    request(1'b0, 18'h0C910);
    drain("post_rst_timeout", 60);

    // boundary angles each take the full iteration count
    dut_steps = 0; request(1'b0, 18'h00000); drain("b0_timeout", 40);
    chk("steps_zero", 64'(dut_steps), 64'(ITER_N));
    dut_steps = 0; request(1'b0, 18'h19220); drain("bpos_timeout", 40);
    chk("steps_pos_max", 64'(dut_steps), 64'(ITER_N));
    dut_steps = 0; request(1'b1, 18'h26DE0); drain("bneg_timeout", 40);
    chk("steps_neg_max", 64'(dut_steps), 64'(ITER_N));

    // random traffic with random backpressure
    traffic_en = 1'b1;
    rdy_mode   = 1;
    repeat (2000) tick();
    traffic_en = 1'b0;
    drain("final_drain_timeout", 400);

    chk("responses_vs_accepts", 64'(dut_rsp), 64'(n_acc));
    chk("exp_q_empty", 64'(exp_q.size()), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
